// File: rtl/lr_seq_ctrl.sv
// Streams NUM_SAMPLES RAM words per epoch to the LR engine, then writes the engine result back to RAM.
// 3 cycles per sample (RD, CAP, SEND); SEND holds smp_data/smp_valid until smp_ready, WAIT_ENG holds until eng_done.
module lr_seq_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int MAX_FEATURES = 6,
  parameter int DATA_WIDTH   = 16*(MAX_FEATURES+1),
  parameter int NUM_SAMPLES  = 10,
  parameter int NUM_EPOCHS   = 2,
  parameter int RESULT_BASE  = 12,
  parameter int EPW          = $clog2(NUM_EPOCHS+1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [EPW-1:0]        epoch,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  smp_valid,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_last,
  input  logic                  smp_ready,
  input  logic                  eng_done,
  input  logic [DATA_WIDTH-1:0] eng_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_SEND, S_WAIT_ENG, S_WB, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST_IDX = ADDR_WIDTH'(NUM_SAMPLES-1);
  localparam logic [ADDR_WIDTH-1:0] LP_RES_BASE = ADDR_WIDTH'(RESULT_BASE);
  localparam logic [EPW-1:0]        LP_LAST_EP  = EPW'(NUM_EPOCHS-1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [EPW-1:0]          r_epoch;
  logic [DATA_WIDTH-1:0]   r_smp_data;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    w_is_last;
  logic                    w_last_ep;
  logic [ADDR_WIDTH-1:0]   w_res_addr;

  assign w_is_last  = (r_idx == LP_LAST_IDX);
  assign w_last_ep  = (r_epoch == LP_LAST_EP);
  assign w_res_addr = LP_RES_BASE + ADDR_WIDTH'(r_epoch);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_epoch    <= '0;
      r_smp_data <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_epoch <= '0;
          end
        end
        S_CAP:  r_smp_data <= ram_rdata;
        S_SEND: begin
          if (smp_ready && !w_is_last) r_idx <= r_idx + ADDR_WIDTH'(1);
        end
        S_WAIT_ENG: begin
          if (eng_done) r_wdata <= eng_result;
        end
        S_WB: begin
          if (!w_last_ep) begin
            r_epoch <= r_epoch + EPW'(1);
            r_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_RD;
      S_RD:       w_next = S_CAP;
      S_CAP:      w_next = S_SEND;
      S_SEND:     if (smp_ready) w_next = w_is_last ? S_WAIT_ENG : S_RD;
      S_WAIT_ENG: if (eng_done) w_next = S_WB;
      S_WB:       w_next = w_last_ep ? S_DONE : S_RD;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    done      = (r_state == S_DONE);
    epoch     = r_epoch;
    ram_oe    = (r_state == S_RD);
    // A write-back cycle coinciding with reset is dropped rather than committed.
    ram_we    = (r_state == S_WB) && !RST;
    ram_wdata = r_wdata;
    smp_valid = (r_state == S_SEND);
    smp_last  = (r_state == S_SEND) && w_is_last;
    smp_data  = r_smp_data;
    ram_addr  = '0;
    if (r_state == S_RD) ram_addr = r_idx;
    else if (r_state == S_WB) ram_addr = w_res_addr;
  end

endmodule

// File: tb/tb_lr_seq_ctrl.sv
// Directed bench for lr_seq_ctrl: default instance plus a one-sample/one-epoch instance.
module tb_lr_seq_ctrl;
  localparam int DW = 112;

  logic          CLK, RST, start, busy, done, ram_oe, ram_we, smp_valid, smp_last, smp_ready, eng_done;
  logic [1:0]    epoch;
  logic [3:0]    ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata, smp_data, eng_result;

  logic          b_start, b_busy, b_done, b_ram_oe, b_ram_we, b_smp_valid, b_smp_last, b_smp_ready, b_eng_done;
  logic [0:0]    b_epoch;
  logic [3:0]    b_ram_addr;
  logic [DW-1:0] b_ram_wdata, b_ram_rdata, b_smp_data, b_eng_result;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_pipe;
  int hs_q[$];
  int wr_cnt, done_cnt, run_cyc, last_cnt, last_bad, res_cnt;
  int bp_en, bp_cnt, stall_cycles, stall_bad, spur_en, eng_pend, eng_wait, eng_delay;
  logic [DW-1:0] stall_ref;
  bit overlap, b_overlap;

  lr_seq_ctrl u_dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done), .epoch(epoch),
    .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .smp_valid(smp_valid), .smp_data(smp_data), .smp_last(smp_last),
    .smp_ready(smp_ready), .eng_done(eng_done), .eng_result(eng_result)
  );

  lr_seq_ctrl #(.NUM_SAMPLES(1), .NUM_EPOCHS(1), .RESULT_BASE(5)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(b_start), .busy(b_busy), .done(b_done), .epoch(b_epoch),
    .ram_addr(b_ram_addr), .ram_oe(b_ram_oe), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .smp_valid(b_smp_valid), .smp_data(b_smp_data), .smp_last(b_smp_last),
    .smp_ready(b_smp_ready), .eng_done(b_eng_done), .eng_result(b_eng_result)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // RAM, engine and handshake recorder; everything is observed and driven on the falling edge.
  initial begin
    rd_pipe = '0;
    forever begin
      @(negedge CLK);
      if (bp_en != 0 && smp_valid && smp_data[15:0] == 16'd3 && bp_cnt < 4) begin
        smp_ready = 1'b0;
        bp_cnt++;
      end else smp_ready = 1'b1;
      if (smp_valid && !smp_ready) begin
        if (stall_cycles == 0) stall_ref = smp_data;
        else if (smp_data !== stall_ref) stall_bad++;
        if (ram_oe) stall_bad++;
        stall_cycles++;
      end
      if (smp_valid && smp_ready) begin
        hs_q.push_back(int'(smp_data[15:0]));
        if (smp_last) begin
          last_cnt++;
          if (smp_data[15:0] != 16'd10) last_bad++;
        end
      end
      eng_done = 1'b0;
      if (eng_pend != 0) begin
        eng_wait++;
        if (eng_wait == eng_delay) begin
          eng_done   = 1'b1;
          eng_result = {7{16'hE000 | 16'(res_cnt)}};
          res_cnt++;
          eng_pend   = 0;
        end
      end
      if (spur_en != 0 && smp_valid && smp_data[15:0] == 16'd5) begin
        eng_done   = 1'b1;
        eng_result = {7{16'hBAD0}};
      end
      if (smp_valid && smp_ready && smp_last) begin
        eng_pend = 1;
        eng_wait = 0;
      end
      ram_rdata = rd_pipe;
      rd_pipe   = ram_oe ? mem[ram_addr] : '0;
      if (ram_we) begin
        mem[ram_addr] = ram_wdata;
        wr_cnt++;
      end
      if (ram_we && ram_oe) overlap = 1'b1;
      if (b_ram_we && b_ram_oe) b_overlap = 1'b1;
      if (busy || done) run_cyc++;
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic init_mem();
    logic [15:0] w;
    for (int k = 0; k < 16; k++) begin
      w = (k < 10) ? 16'(k + 1) : 16'(16'hD000 + k);
      mem[k] = {7{w}};
    end
  endtask

  task automatic clear_stats();
    hs_q.delete();
    wr_cnt = 0; done_cnt = 0; run_cyc = 0; last_cnt = 0; last_bad = 0; res_cnt = 0;
    bp_en = 0; bp_cnt = 0; stall_cycles = 0; stall_bad = 0; spur_en = 0;
    eng_pend = 0; eng_wait = 0; eng_delay = 2;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge CLK); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic count_seq_err(output int err);
    err = 0;
    for (int i = 0; i < hs_q.size(); i++)
      if (hs_q[i] != (i % 10) + 1) err++;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    total++; if ({busy, done, epoch, ram_addr, ram_oe, ram_we, smp_valid, smp_last} !== 12'h0) begin
      bad++; $display("FAIL reset_ctrl got=%h want=0", {busy, done, epoch, ram_addr, ram_oe, ram_we, smp_valid, smp_last}); end
    total++; if (ram_wdata !== '0 || smp_data !== '0) begin
      bad++; $display("FAIL reset_data wdata=%h smp=%h want=0", ram_wdata, smp_data); end
    total++; if ({b_busy, b_done, b_ram_addr, b_ram_oe, b_ram_we, b_smp_valid} !== 9'h0) begin
      bad++; $display("FAIL reset_single got=%h want=0", {b_busy, b_done, b_ram_addr, b_ram_oe, b_ram_we, b_smp_valid}); end
    RST = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok;
    int err;
    init_mem(); clear_stats();
    pulse_start();
    total++; if ({busy, ram_oe, ram_addr, epoch} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
      bad++; $display("FAIL nom_first_rd got busy=%b oe=%b addr=%0d ep=%0d want 1 1 0 0", busy, ram_oe, ram_addr, epoch); end
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL nom_timeout done not seen"); end
    count_seq_err(err);
    total++; if (hs_q.size() != 20 || err != 0) begin
      bad++; $display("FAIL nom_handshakes got n=%0d err=%0d want n=20 err=0", hs_q.size(), err); end
    total++; if (mem[12] !== {7{16'hE000}} || mem[13] !== {7{16'hE001}}) begin
      bad++; $display("FAIL nom_results got %h %h want e000.. e001..", mem[12][15:0], mem[13][15:0]); end
    total++; if (wr_cnt != 2 || done_cnt != 1) begin
      bad++; $display("FAIL nom_counts writes=%0d done=%0d want 2 1", wr_cnt, done_cnt); end
    total++; if (run_cyc != 67) begin bad++; $display("FAIL nom_cycles got=%0d want=67", run_cyc); end
    total++; if (last_cnt != 2 || last_bad != 0) begin
      bad++; $display("FAIL nom_last got cnt=%0d bad=%0d want 2 0", last_cnt, last_bad); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL nom_idle busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int err;
    init_mem(); clear_stats();
    bp_en = 1;
    pulse_start();
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout done not seen"); end
    total++; if (stall_cycles != 4 || stall_bad != 0) begin
      bad++; $display("FAIL bp_stall got cycles=%0d unstable=%0d want 4 0", stall_cycles, stall_bad); end
    total++; if (stall_ref !== {7{16'd3}}) begin bad++; $display("FAIL bp_word got=%h want 3s", stall_ref); end
    count_seq_err(err);
    total++; if (hs_q.size() != 20 || err != 0) begin
      bad++; $display("FAIL bp_handshakes got n=%0d err=%0d want n=20 err=0", hs_q.size(), err); end
    total++; if (run_cyc != 71) begin bad++; $display("FAIL bp_cycles got=%0d want=71", run_cyc); end
  endtask

  task automatic test_spurious_eng_done();
    bit ok;
    init_mem(); clear_stats();
    spur_en = 1; eng_delay = 3;
    pulse_start();
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL spur_timeout done not seen"); end
    total++; if (wr_cnt != 2) begin bad++; $display("FAIL spur_writes got=%0d want=2", wr_cnt); end
    total++; if (mem[12] !== {7{16'hE000}} || mem[13] !== {7{16'hE001}}) begin
      bad++; $display("FAIL spur_results got %h %h want e000.. e001..", mem[12][15:0], mem[13][15:0]); end
    total++; if (run_cyc != 69 || hs_q.size() != 20) begin
      bad++; $display("FAIL spur_cycles got cyc=%0d hs=%0d want 69 20", run_cyc, hs_q.size()); end
  endtask

  task automatic test_rst_in_wb();
    bit ok;
    init_mem(); clear_stats();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ram_we) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    total++; if (!ok) begin bad++; $display("FAIL rst_wb_timeout write-back not seen"); end
    RST = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we_gate got=%b want=0", ram_we); end
    @(posedge CLK); #1;
    total++; if ({busy, done, epoch, ram_addr, ram_oe, ram_we, smp_valid, smp_last} !== 12'h0 ||
                 ram_wdata !== '0 || smp_data !== '0) begin
      bad++; $display("FAIL rst_outputs got ctrl=%h wdata=%h smp=%h want 0", {busy, done, epoch, ram_addr, ram_oe, ram_we, smp_valid, smp_last}, ram_wdata, smp_data); end
    RST = 1'b0;
    @(negedge CLK); #1;
    total++; if (mem[12] !== {7{16'hD00C}} || wr_cnt != 0) begin
      bad++; $display("FAIL rst_no_write got mem12=%h writes=%0d want d00c 0", mem[12][15:0], wr_cnt); end
    clear_stats();
    pulse_start();
    total++; if ({busy, ram_oe, ram_addr, epoch} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
      bad++; $display("FAIL rst_restart got busy=%b oe=%b addr=%0d ep=%0d want 1 1 0 0", busy, ram_oe, ram_addr, epoch); end
    wait_done(400, ok);
    total++; if (!ok || hs_q.size() != 20 || mem[12] !== {7{16'hE000}}) begin
      bad++; $display("FAIL rst_rerun got ok=%b hs=%0d mem12=%h want 1 20 e000", ok, hs_q.size(), mem[12][15:0]); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    init_mem(); clear_stats();
    pulse_start();
    repeat (10) @(posedge CLK);
    #1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    wait_done(400, ok);
    total++; if (!ok || run_cyc != 67 || done_cnt != 1 || hs_q.size() != 20) begin
      bad++; $display("FAIL busy_start got ok=%b cyc=%0d done=%0d hs=%0d want 1 67 1 20", ok, run_cyc, done_cnt, hs_q.size()); end
    repeat (3) @(posedge CLK);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle busy=%b want 0", busy); end
  endtask

  task automatic test_start_held();
    bit ok;
    init_mem(); clear_stats();
    @(posedge CLK); #1; start = 1'b1;
    @(posedge CLK); #1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL held_done got ok=%b busy=%b want 1 0", ok, busy); end
    @(posedge CLK); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL held_idle got busy=%b done=%b want 0 0", busy, done); end
    @(posedge CLK); #1;
    total++; if ({busy, ram_oe, ram_addr, epoch} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
      bad++; $display("FAIL held_restart got busy=%b oe=%b addr=%0d ep=%0d want 1 1 0 0", busy, ram_oe, ram_addr, epoch); end
    start = 1'b0;
    wait_done(400, ok);
    total++; if (!ok || done_cnt != 2 || hs_q.size() != 40) begin
      bad++; $display("FAIL held_two_runs got ok=%b done=%0d hs=%0d want 1 2 40", ok, done_cnt, hs_q.size()); end
  endtask

  task automatic test_single();
    logic [DW-1:0] word, res;
    word = {7{16'h1234}};
    res  = {7{16'h7777}};
    b_ram_rdata = word;
    @(posedge CLK); #1; b_start = 1'b1;
    @(posedge CLK); #1; b_start = 1'b0;
    total++; if ({b_busy, b_ram_oe, b_ram_we, b_ram_addr} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL one_rd got busy=%b oe=%b we=%b addr=%0d want 1 1 0 0", b_busy, b_ram_oe, b_ram_we, b_ram_addr); end
    @(posedge CLK); #1;
    total++; if (b_ram_oe !== 1'b0 || b_smp_valid !== 1'b0) begin
      bad++; $display("FAIL one_cap got oe=%b valid=%b want 0 0", b_ram_oe, b_smp_valid); end
    @(posedge CLK); #1;
    total++; if (b_smp_valid !== 1'b1 || b_smp_last !== 1'b1 || b_smp_data !== word) begin
      bad++; $display("FAIL one_send got valid=%b last=%b data=%h want 1 1 1234..", b_smp_valid, b_smp_last, b_smp_data); end
    @(posedge CLK); #1;
    total++; if (b_smp_valid !== 1'b0 || b_busy !== 1'b1 || b_ram_we !== 1'b0) begin
      bad++; $display("FAIL one_wait got valid=%b busy=%b we=%b want 0 1 0", b_smp_valid, b_busy, b_ram_we); end
    b_eng_done = 1'b1; b_eng_result = res;
    @(posedge CLK); #1;
    b_eng_done = 1'b0; b_eng_result = '0;
    total++; if (b_ram_we !== 1'b1 || b_ram_oe !== 1'b0 || b_ram_addr !== 4'd5 || b_ram_wdata !== res) begin
      bad++; $display("FAIL one_wb got we=%b oe=%b addr=%0d wdata=%h want 1 0 5 7777..", b_ram_we, b_ram_oe, b_ram_addr, b_ram_wdata); end
    @(posedge CLK); #1;
    total++; if (b_done !== 1'b1 || b_busy !== 1'b0 || b_ram_we !== 1'b0) begin
      bad++; $display("FAIL one_done got done=%b busy=%b we=%b want 1 0 0", b_done, b_busy, b_ram_we); end
    @(posedge CLK); #1;
    total++; if (b_done !== 1'b0) begin bad++; $display("FAIL one_done_pulse got=%b want=0", b_done); end
    total++; if (overlap || b_overlap) begin
      bad++; $display("FAIL we_oe_overlap got main=%b single=%b want 0 0", overlap, b_overlap); end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; smp_ready = 1'b1; eng_done = 1'b0; eng_result = '0; ram_rdata = '0;
    b_start = 1'b0; b_smp_ready = 1'b1; b_eng_done = 1'b0; b_eng_result = '0; b_ram_rdata = '0;
    overlap = 1'b0; b_overlap = 1'b0;
    init_mem(); clear_stats();
    test_reset();
    test_nominal();
    test_backpressure();
    test_spurious_eng_done();
    test_rst_in_wb();
    test_start_while_busy();
    test_start_held();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
